vga_fb_fetch: RTL and testbench

- Framebuffer fetch stage directly upstream of the VGA timing/pixel-output block.
- Reads the active framebuffer from memory with AXI4 INCR read bursts and buffers the words in an internal FIFO.
- Supplies one 16-bit pixel per request to the timing block's pixel-data input (used when test mode is off).
- Restarts from the framebuffer base address at every frame start.

---
 rtl/vga_fetch_pkg.sv | 15 +
 rtl/vga_fetch_fifo.sv | 54 +++++
 rtl/vga_fb_fetch.sv | 143 ++++++++++++++
 tb/tb_vga_fb_fetch.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fetch_pkg.sv
// Shared types and AXI constants for the VGA framebuffer fetch stage.
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        FLUSH = 2'd3
    } fsm_e;

    localparam logic [1:0] INCR    = 2'b01;
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [2:0] SIZE_4B = 3'b010;

endpackage

// File: rtl/vga_fetch_fifo.sv
// Synchronous word FIFO with flush and occupancy count.
module vga_fetch_fifo
    import vga_fetch_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int W     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wp] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush_i) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_i) wp <= wp + 1'b1;
            if (pop_i)  rp <= rp + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata_o = mem[rp];
    assign count_o = cnt;
    assign empty_o = (cnt == '0);

endmodule

// File: rtl/vga_fb_fetch.sv
// Framebuffer fetch: AXI4 INCR bursts into a FIFO, one 16-bit pixel per request.
module vga_fb_fetch
    import vga_fetch_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [AXI_ADDR_W-1:0] fb_base_i,
    input  logic [19:0]           fb_words_i,
    input  logic                  frame_start_i,
    input  logic                  pix_req_i,
    output logic [15:0]           pix_data_o,
    output logic                  underflow_o,
    output logic                  rerr_o,
    input  logic                  clr_i,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    output logic [AXI_ADDR_W-1:0] araddr_o,
    output logic [7:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    output logic [AXI_ID_W-1:0]   arid_o,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic [31:0]           rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fsm_e          state;
    fsm_e          state_nx;
    logic [19:0]   offset;
    logic          half;
    logic          pend;
    logic          beat;
    logic          ar_hs;
    logic          want_flush;
    logic          start_burst;
    logic          take;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          fifo_empty;
    logic [31:0]   fifo_head;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] free_slots;

    assign ar_hs      = (state == ADDR) && arready_i;
    assign beat       = (state == DATA) && rvalid_i;
    assign want_flush = pend || frame_start_i;
    assign fifo_flush = (state == FLUSH);
    assign take       = pix_req_i && !fifo_empty;
    assign fifo_pop   = take && half;

    // Bursts only launch from IDLE, so nothing is reserved when this is sampled.
    assign free_slots  = CW'(FIFO_DEPTH) - fifo_cnt;
    assign start_burst = en_i && !want_flush
                       && (offset < fb_words_i)
                       && (free_slots >= CW'(BURST_LEN));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (want_flush)       state_nx = FLUSH;
                else if (start_burst) state_nx = ADDR;
            end
            ADDR: if (arready_i) state_nx = DATA;
            DATA: begin
                if (rvalid_i && rlast_i)
                    state_nx = want_flush ? FLUSH : IDLE;
            end
            FLUSH:   state_nx = frame_start_i ? FLUSH : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            offset   <= '0;
            pend     <= 1'b0;
            half     <= 1'b0;
            araddr_o <= '0;
        end else begin
            state <= state_nx;
            if (fifo_flush)                offset <= '0;
            else if (ar_hs)                offset <= offset + 20'(BURST_LEN);
            if (fifo_flush)                pend <= 1'b0;
            else if (frame_start_i)        pend <= 1'b1;
            if (fifo_flush)                half <= 1'b0;
            else if (take)                 half <= ~half;
            if (state == IDLE && start_burst)
                araddr_o <= fb_base_i + AXI_ADDR_W'({offset, 2'b00});
        end
    end

    // Sticky flags: a new event on the same cycle beats the clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pix_data_o  <= '0;
            underflow_o <= 1'b0;
            rerr_o      <= 1'b0;
        end else begin
            if (pix_req_i)
                pix_data_o <= fifo_empty ? 16'h0000
                            : (half ? fifo_head[31:16] : fifo_head[15:0]);
            if (pix_req_i && fifo_empty) underflow_o <= 1'b1;
            else if (clr_i)              underflow_o <= 1'b0;
            if (beat && rresp_i != OKAY) rerr_o <= 1'b1;
            else if (clr_i)              rerr_o <= 1'b0;
        end
    end

    vga_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (beat),
        .wdata_i (rdata_i),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .rdata_o (fifo_head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

    assign arvalid_o = (state == ADDR);
    assign rready_o  = (state == DATA);
    assign arlen_o   = 8'(BURST_LEN - 1);
    assign arsize_o  = SIZE_4B;
    assign arburst_o = INCR;
    assign arid_o    = '0;

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Scoreboard bench for vga_fb_fetch with a zero-wait AXI read slave.
module tb_vga_fb_fetch;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        en_i = 1'b0;
    logic [31:0] fb_base_i = BASE;
    logic [19:0] fb_words_i = 20'd32;
    logic        frame_start_i = 1'b0;
    logic        pix_req_i = 1'b0;
    logic        clr_i = 1'b0;
    logic        arready_i = 1'b0;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic [1:0]  rresp_i = '0;
    logic        rlast_i = 1'b0;
    logic [15:0] pix_data_o;
    logic        underflow_o;
    logic        rerr_o;
    logic        arvalid_o;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic [3:0]  arid_o;
    logic        rready_o;

    int          tests_run = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    logic [31:0] ar_log[$];
    int          burst_beats[$];
    int          ar_gap[$];
    bit          act = 1'b0;
    logic [31:0] cur = '0;
    int          beats = 0;
    int          last_rlast_cyc = 0;
    bit          clr_on_ar = 1'b0;
    bit          err_arm = 1'b0;
    int          err_beat = 3;
    int          ar_bad = 0;
    logic [7:0]  salt = 8'h00;

    always #5 clk = ~clk;

    vga_fb_fetch dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .en_i          (en_i),
        .fb_base_i     (fb_base_i),
        .fb_words_i    (fb_words_i),
        .frame_start_i (frame_start_i),
        .pix_req_i     (pix_req_i),
        .pix_data_o    (pix_data_o),
        .underflow_o   (underflow_o),
        .rerr_o        (rerr_o),
        .clr_i         (clr_i),
        .arvalid_o     (arvalid_o),
        .arready_i     (arready_i),
        .araddr_o      (araddr_o),
        .arlen_o       (arlen_o),
        .arsize_o      (arsize_o),
        .arburst_o     (arburst_o),
        .arid_o        (arid_o),
        .rvalid_i      (rvalid_i),
        .rready_o      (rready_o),
        .rdata_i       (rdata_i),
        .rresp_i       (rresp_i),
        .rlast_i       (rlast_i)
    );

    function automatic logic [31:0] pat(input logic [31:0] a, input logic [7:0] s);
        logic [15:0] k;
        k = a[17:2];
        return {k ^ 16'hA5C3 ^ {8'h00, s}, k ^ {s, 8'h1E}};
    endfunction

    // Slave/monitor: records handshakes and pushes expected pixels per beat.
    always @(posedge clk) begin
        if (!rst_n_i) begin
            act     = 1'b0;
            beats   = 0;
            err_arm = 1'b0;
        end else begin
            if (rvalid_i && rready_o) begin
                exp_q.push_back(rdata_i[15:0]);
                exp_q.push_back(rdata_i[31:16]);
                beats++;
                if (rlast_i) begin
                    act = 1'b0;
                    burst_beats.push_back(beats);
                    beats = 0;
                    last_rlast_cyc = cyc;
                    err_arm = 1'b0;
                end
            end
            if (arvalid_o && arready_i) begin
                if (clr_on_ar) begin
                    exp_q.delete();
                    clr_on_ar = 1'b0;
                end
                if (arlen_o !== 8'd15 || arsize_o !== 3'b010 ||
                    arburst_o !== 2'b01 || arid_o !== 4'd0)
                    ar_bad++;
                ar_log.push_back(araddr_o);
                ar_gap.push_back(cyc - last_rlast_cyc);
                act   = 1'b1;
                cur   = araddr_o;
                beats = 0;
            end
        end
        cyc++;
    end

    initial begin
        forever begin
            @(negedge clk);
            arready_i = 1'b1;
            rvalid_i  = act;
            rdata_i   = act ? pat(cur + 32'(beats * 4), salt) : 32'h0;
            rlast_i   = act && (beats == 15);
            rresp_i   = (act && err_arm && beats == err_beat) ? 2'b10 : 2'b00;
        end
    end

    task automatic pulse_frame();
        salt = salt + 8'd1;
        frame_start_i = 1'b1;
        @(negedge clk);
        frame_start_i = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
    endtask

    task automatic drain(input int n, input string nm);
        logic [15:0] e;
        bit          uf;
        for (int i = 0; i < n; i++) begin
            uf = (exp_q.size() == 0);
            if (uf) e = 16'h0000;
            else    e = exp_q.pop_front();
            pix_req_i = 1'b1;
            @(negedge clk);
            tests_run++;
            if (pix_data_o !== e) begin
                fails++;
                $display("FAIL %s pix[%0d]: got %h want %h", nm, i, pix_data_o, e);
            end
            if (uf) begin
                tests_run++;
                if (underflow_o !== 1'b1) begin
                    fails++;
                    $display("FAIL %s underflow[%0d]: got %b want 1", nm, i, underflow_o);
                end
            end
        end
        pix_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({arvalid_o, rready_o, underflow_o, rerr_o} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 0000",
                     {arvalid_o, rready_o, underflow_o, rerr_o});
        end
        tests_run++;
        if (pix_data_o !== 16'h0) begin
            fails++;
            $display("FAIL reset_pix: got %h want 0000", pix_data_o);
        end
        tests_run++;
        if (araddr_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_araddr: got %h want 0", araddr_o);
        end
        rst_n_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_burst();
        ar_log.delete();
        burst_beats.delete();
        ar_bad = 0;
        fb_words_i = 20'd32;
        en_i = 1'b1;
        for (int i = 0; i < 300 && burst_beats.size() < 2; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        tests_run++;
        if (ar_log.size() != 2 || ar_log[0] !== BASE || ar_log[1] !== BASE + 32'h40) begin
            fails++;
            $display("FAIL basic_ar: got %0d ARs want 2 at %h,%h",
                     ar_log.size(), BASE, BASE + 32'h40);
        end
        tests_run++;
        if (ar_bad != 0) begin
            fails++;
            $display("FAIL basic_arfields: got %0d bad ARs want 0", ar_bad);
        end
        drain(64, "basic");
        tests_run++;
        if (exp_q.size() != 0 || ar_log.size() != 2) begin
            fails++;
            $display("FAIL basic_eof: got q=%0d ars=%0d want 0,2", exp_q.size(), ar_log.size());
        end
    endtask

    task automatic test_backpressure();
        ar_log.delete();
        clr_on_ar = 1'b1;
        fb_words_i = 20'd128;
        pulse_frame();
        repeat (250) @(negedge clk);
        tests_run++;
        if (ar_log.size() != 4 || exp_q.size() != 128) begin
            fails++;
            $display("FAIL bp_stall: got ars=%0d q=%0d want 4,128", ar_log.size(), exp_q.size());
        end
        drain(32, "bp_pop");
        repeat (100) @(negedge clk);
        tests_run++;
        if (ar_log.size() != 5 || ar_log[4] !== BASE + 32'h100) begin
            fails++;
            $display("FAIL bp_refill: got ars=%0d want 5 (5th at %h)", ar_log.size(), BASE + 32'h100);
        end
    endtask

    task automatic test_frame_mid_burst();
        bit hit;
        ar_log.delete();
        burst_beats.delete();
        ar_gap.delete();
        clr_on_ar = 1'b1;
        fb_words_i = 20'd64;
        pulse_frame();
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            hit = (ar_log.size() == 2 && act && beats == 5);
            if (!hit) @(negedge clk);
        end
        tests_run++;
        if (!hit) begin
            fails++;
            $display("FAIL fs_reach: got ars=%0d beats=%0d want 2,5", ar_log.size(), beats);
        end
        clr_on_ar = 1'b1;
        pulse_frame();
        for (int i = 0; i < 200 && ar_log.size() < 3; i++) @(negedge clk);
        tests_run++;
        if (ar_log.size() < 3 || ar_log[2] !== BASE) begin
            fails++;
            $display("FAIL fs_restart: got ars=%0d want 3rd AR at %h", ar_log.size(), BASE);
        end
        tests_run++;
        if (burst_beats.size() < 2 || burst_beats[1] != 16) begin
            fails++;
            $display("FAIL fs_beats: got %0d bursts done want burst2 with 16 beats", burst_beats.size());
        end
        tests_run++;
        if (ar_gap.size() < 3 || ar_gap[1] != 2 || ar_gap[2] != 3) begin
            fails++;
            $display("FAIL fs_gap: got %0d gaps want plain gap 2, flush gap 3", ar_gap.size());
        end
        for (int i = 0; i < 200 && exp_q.size() < 32; i++) @(negedge clk);
        drain(32, "fs_data");
    endtask

    task automatic test_underflow();
        int n;
        en_i = 1'b0;
        repeat (60) @(negedge clk);
        n = ar_log.size();
        drain(exp_q.size(), "uf_drain");
        tests_run++;
        if (underflow_o !== 1'b0) begin
            fails++;
            $display("FAIL uf_pre: got %b want 0", underflow_o);
        end
        drain(1, "uf_empty");
        repeat (5) @(negedge clk);
        tests_run++;
        if (underflow_o !== 1'b1 || pix_data_o !== 16'h0) begin
            fails++;
            $display("FAIL uf_sticky: got uf=%b pix=%h want 1,0000", underflow_o, pix_data_o);
        end
        pulse_clr();
        tests_run++;
        if (underflow_o !== 1'b0) begin
            fails++;
            $display("FAIL uf_clr: got %b want 0", underflow_o);
        end
        tests_run++;
        if (ar_log.size() != n) begin
            fails++;
            $display("FAIL uf_noar: got %0d ARs want %0d", ar_log.size(), n);
        end
    endtask

    task automatic test_rerr();
        burst_beats.delete();
        clr_on_ar = 1'b1;
        err_beat = 3;
        err_arm = 1'b1;
        fb_words_i = 20'd16;
        en_i = 1'b1;
        pulse_frame();
        for (int i = 0; i < 200 && burst_beats.size() < 1; i++) @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (rerr_o !== 1'b1) begin
            fails++;
            $display("FAIL rerr_set: got %b want 1", rerr_o);
        end
        tests_run++;
        if (burst_beats.size() != 1 || burst_beats[0] != 16 || exp_q.size() != 32) begin
            fails++;
            $display("FAIL rerr_beats: got bursts=%0d q=%0d want 1,32", burst_beats.size(), exp_q.size());
        end
        drain(32, "rerr_data");
        pulse_clr();
        tests_run++;
        if (rerr_o !== 1'b0) begin
            fails++;
            $display("FAIL rerr_clr: got %b want 0", rerr_o);
        end
    endtask

    task automatic test_async_reset();
        bit hit;
        ar_log.delete();
        clr_on_ar = 1'b1;
        err_beat = 2;
        err_arm = 1'b1;
        fb_words_i = 20'd64;
        pulse_frame();
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            hit = (ar_log.size() >= 1 && act && beats == 7);
            if (!hit) @(negedge clk);
        end
        tests_run++;
        if (!hit || rerr_o !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre: got reach=%b rerr=%b want 1,1", hit, rerr_o);
        end
        #2 rst_n_i = 1'b0;
        #1;
        tests_run++;
        if ({arvalid_o, rready_o, underflow_o, rerr_o} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_ctl: got %b want 0000", {arvalid_o, rready_o, underflow_o, rerr_o});
        end
        tests_run++;
        if (pix_data_o !== 16'h0) begin
            fails++;
            $display("FAIL rst_pix: got %h want 0000", pix_data_o);
        end
        exp_q.delete();
        clr_on_ar = 1'b0;
        ar_log.delete();
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
        for (int i = 0; i < 50 && ar_log.size() < 1; i++) @(negedge clk);
        tests_run++;
        if (ar_log.size() < 1 || ar_log[0] !== BASE) begin
            fails++;
            $display("FAIL rst_restart: got %0d ARs want first at %h", ar_log.size(), BASE);
        end
        for (int i = 0; i < 200 && exp_q.size() < 32; i++) @(negedge clk);
        drain(32, "rst_data");
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_frame_mid_burst();
        test_underflow();
        test_rerr();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
